exp_table_store: RTL and testbench

Double-buffered 64-entry table store that sits directly downstream of the exp-sigma calculator. It captures the calculator's (address, data, valid) write stream into the inactive bank and checks that all 64 entries arrived. On the calculator's done strobe it commits the bank atomically and publishes the table sum. Downstream risk logic reads a stable, complete table through a registered read port while the next table is being filled.

---
 rtl/exp_table_store.sv | 77 +++++++
 tb/tb_exp_table_store.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/exp_table_store.sv
// exp_table_store: double-buffered 64-entry table. It fills the inactive bank from the
// exp-sigma write stream, commits the table when it is complete, and publishes the table sum.
//   CLK/RST_N    clock, synchronous active-low reset
//   iData/iAddr  write data and index, qualified by iValid
//   iDone        end-of-table strobe
//   iRdAddr      read index into the committed bank
//   oRdData      registered read data (1-cycle latency)
//   oTableReady  a table has been committed since reset
//   oSum         sum of the committed table
//   oCommit      one-cycle commit pulse
//   oErr         one-cycle pulse when iDone arrives with missing entries
module exp_table_store #(
    parameter int DEPTH_LOG2 = 6,
    parameter int DATA_W     = 17,
    parameter int SUM_W      = 23
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [DATA_W-1:0]     iData,
    input  logic [DEPTH_LOG2-1:0] iAddr,
    input  logic                  iValid,
    input  logic                  iDone,
    input  logic [DEPTH_LOG2-1:0] iRdAddr,
    output logic [DATA_W-1:0]     oRdData,
    output logic                  oTableReady,
    output logic [SUM_W-1:0]      oSum,
    output logic                  oCommit,
    output logic                  oErr
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    typedef enum logic [1:0] {FILL, COMMIT, ERROR} state_t;
    state_t            state;
    logic              act;
    logic [DEPTH-1:0]  mask, mask_w;
    logic [SUM_W-1:0]  acc, acc_w;
    logic [DATA_W-1:0] mem [0:1][0:DEPTH-1];
    logic [DATA_W-1:0] old_val;
    logic              clr, wr_bank, rd_bank;
    // In COMMIT, act flips at the end of the cycle. Writes in that cycle therefore go to
    // the bank that is about to become inactive, and reads already see the new table.
    always_comb begin
        clr     = state != FILL;
        wr_bank = (state == COMMIT) ? act : ~act;
        rd_bank = (state == COMMIT) ? ~act : act;
        old_val = mem[wr_bank][iAddr];
        // A duplicate write replaces the earlier value in the sum. The bank itself holds that old value.
        mask_w  = (clr ? '0 : mask) | ({{(DEPTH-1){1'b0}}, iValid} << iAddr);
        acc_w   = (clr ? '0 : acc)
                + (iValid ? SUM_W'(iData) - ((!clr && mask[iAddr]) ? SUM_W'(old_val) : '0) : '0);
    end
    always_ff @(posedge CLK)
        if (RST_N && iValid) mem[wr_bank][iAddr] <= iData;
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state       <= FILL;
            act         <= 1'b0;
            mask        <= '0;
            acc         <= '0;
            oSum        <= '0;
            oTableReady <= 1'b0;
            oCommit     <= 1'b0;
            oErr        <= 1'b0;
            oRdData     <= '0;
        end else begin
            // The completeness check counts a write that arrives in the same cycle as iDone.
            state       <= (state == FILL && iDone) ? ((&mask_w) ? COMMIT : ERROR) : FILL;
            act         <= act ^ (state == COMMIT);
            mask        <= mask_w;
            acc         <= acc_w;
            oSum        <= (state == COMMIT) ? acc : oSum;
            oTableReady <= oTableReady | (state == COMMIT);
            oCommit     <= state == COMMIT;
            oErr        <= state == ERROR;
            oRdData     <= mem[rd_bank][iRdAddr];
        end
    end
endmodule

// File: tb/tb_exp_table_store.sv
// tb_exp_table_store: randomized checks of exp_table_store against a table-level reference model
module tb_exp_table_store;
    logic        CLK = 1'b0, RST_N = 1'b0;
    logic [16:0] iData = '0;
    logic [5:0]  iAddr = '0, iRdAddr = '0;
    logic        iValid = 1'b0, iDone = 1'b0;
    logic [16:0] oRdData;
    logic        oTableReady, oCommit, oErr;
    logic [22:0] oSum;
    int n_tests = 0, n_fail = 0;
    int committed[64], staged[64], fill[64];
    bit have[64];
    bit ready = 0;
    int sum = 0, pend = 0;

    exp_table_store dut (
        .CLK(CLK), .RST_N(RST_N), .iData(iData), .iAddr(iAddr), .iValid(iValid),
        .iDone(iDone), .iRdAddr(iRdAddr), .oRdData(oRdData), .oTableReady(oTableReady),
        .oSum(oSum), .oCommit(oCommit), .oErr(oErr)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // pend: 0 = none, 1 = table staged for commit, 2 = incomplete table rejected
    task automatic step(input bit v, input int a, input int d, input bit dn, input int ra);
        bit c, e;
        int cnt, np;
        iValid = v; iAddr = 6'(a); iData = 17'(d); iDone = dn; iRdAddr = 6'(ra);
        @(posedge CLK);
        c = 0; e = 0; np = 0; cnt = 0;
        if (!RST_N) begin
            ready = 0; sum = 0; pend = 0;
            foreach (have[i]) have[i] = 0;
        end else begin
            c = pend == 1;
            e = pend == 2;
            if (c) begin
                committed = staged;
                ready = 1;
                sum = 0;
                foreach (staged[i]) sum += staged[i];
            end
            if (v) begin fill[a] = d; have[a] = 1; end
            if (pend == 0 && dn) begin
                foreach (have[i]) cnt += int'(have[i]);
                np = (cnt == 64) ? 1 : 2;
                if (np == 1) staged = fill;
                foreach (have[i]) have[i] = 0;
            end
            pend = np;
        end
        #1;
        check("commit", 32'(oCommit), 32'(c));
        check("err", 32'(oErr), 32'(e));
        check("ready", 32'(oTableReady), 32'(ready));
        check("sum", 32'(oSum), sum);
        if (!RST_N) check("rd_rst", 32'(oRdData), 0);
        else if (ready) check("rd", 32'(oRdData), committed[ra]);
    endtask

    task automatic idle(input int ra);
        step(0, 0, 0, 0, ra);
    endtask

    // mode 0: 1024, 1: addr*16, 2: 65536, 3: random. The entry at index skip is left out.
    task automatic sweep(input int mode, input int skip, input bit dn_last);
        int val;
        for (int a = 0; a < 64; a++) begin
            val = mode == 0 ? 1024 : mode == 1 ? a * 16 : mode == 2 ? 65536 : int'($urandom_range(65536));
            step(a != skip, a, val, dn_last && a == 63, int'($urandom_range(63)));
        end
    endtask

    initial begin
        int p[64];
        int j, t;
        RST_N = 1'b0;
        idle(0);
        idle(0);
        RST_N = 1'b1;
        sweep(0, -1, 1);
        idle(0);
        check("t1_sum", 32'(oSum), 65536);
        check("t1_commit", 32'(oCommit), 1);
        for (int i = 0; i < 64; i++) begin
            idle(i);
            check("t1_rd", 32'(oRdData), 1024);
        end
        sweep(1, -1, 1);
        idle(7);
        check("t2_sum", 32'(oSum), 32256);
        check("t2_rd7", 32'(oRdData), 112);
        sweep(0, 37, 1);
        idle(37);
        check("t3_err", 32'(oErr), 1);
        check("t3_sum", 32'(oSum), 32256);
        check("t3_rd37", 32'(oRdData), 592);
        sweep(0, -1, 0);
        step(1, 5, 0, 0, 5);
        step(0, 0, 0, 1, 5);
        idle(5);
        check("t4_sum", 32'(oSum), 64512);
        check("t4_rd5", 32'(oRdData), 0);
        sweep(2, -1, 1);
        idle(63);
        check("t5_sum", 32'(oSum), 4194304);
        for (int i = 0; i < 30; i++) step(1, i, int'($urandom_range(65536)), 0, i);
        RST_N = 1'b0;
        idle(0);
        RST_N = 1'b1;
        check("rst_ready", 32'(oTableReady), 0);
        sweep(3, -1, 1);
        idle(1);
        idle(2);
        // back-to-back shuffled tables with duplicate rewrites
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 64; i++) p[i] = i;
            for (int i = 63; i > 0; i--) begin
                j = int'($urandom_range(i));
                t = p[i]; p[i] = p[j]; p[j] = t;
            end
            for (int i = 0; i < 64; i++)
                step(1, p[i], int'($urandom_range(65536)), 0, int'($urandom_range(63)));
            for (int i = 0; i < 8; i++)
                step(1, int'($urandom_range(63)), int'($urandom_range(65536)), i == 7, int'($urandom_range(63)));
        end
        for (int i = 0; i < 400; i++)
            step($urandom_range(9) < 8, int'($urandom_range(63)), int'($urandom_range(65536)),
                 $urandom_range(29) == 0, int'($urandom_range(63)));
        sweep(3, -1, 1);
        step(0, 0, 0, 1, 3);
        idle(4);
        idle(5);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
